// File: rtl/wifi_rx_depuncture34_pkg.sv
// Shared definitions for the rate-3/4 receive depuncturer.
// Holds the default soft-bit width and FIFO depth, the phase encoding of
// the received group (A0 B0 A1 B2) and the rate-3/4 puncture pattern.
package wifi_rx_depuncture34_pkg;

  localparam int SOFT_W_DEFAULT     = 3;
  localparam int FIFO_DEPTH_DEFAULT = 4;

  // Position of the next received bit inside one punctured group.
  typedef enum logic [1:0] {
    PH_A0 = 2'd0,
    PH_B0 = 2'd1,
    PH_A1 = 2'd2,
    PH_B2 = 2'd3
  } phase_t;

  // Keep mask over the mother-code bits {A0, B0, A1, B1, A2, B2}.
  localparam logic [5:0] PUNCT_KEEP = 6'b111001;

  // Puncture flags of the two dropped mother bits.
  localparam logic ERASE_B1 = ~PUNCT_KEEP[2];
  localparam logic ERASE_A2 = ~PUNCT_KEEP[1];

  // Width of one stored pair {a, b, erase_a, erase_b, last}.
  function automatic int pair_w(input int soft_w);
    return 2 * soft_w + 3;
  endfunction

endpackage

// File: rtl/wifi_rx_depuncturer_fifo.sv
// Pair FIFO between the depuncture controller and the Viterbi decoder.
// Ports:
//   clk, reset                 clock and synchronous active-high reset
//   push, a, b, erase_a,
//   erase_b, last              write side, one pair per push
//   pop                        read side, pops the head when valid
//   full                       occupancy equals DEPTH (registered count)
//   valid                      head pair present
//   a_out .. last_out          head pair, all-zero while empty
module wifi_rx_depuncturer_fifo
  import wifi_rx_depuncture34_pkg::*;
#(
  parameter int SOFT_W = SOFT_W_DEFAULT,
  parameter int DEPTH  = FIFO_DEPTH_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic [SOFT_W-1:0] a,
  input  logic [SOFT_W-1:0] b,
  input  logic              erase_a,
  input  logic              erase_b,
  input  logic              last,
  input  logic              pop,
  output logic              full,
  output logic              valid,
  output logic [SOFT_W-1:0] a_out,
  output logic [SOFT_W-1:0] b_out,
  output logic              erase_a_out,
  output logic              erase_b_out,
  output logic              last_out
);

  localparam int W  = pair_w(SOFT_W);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic [W-1:0]  head;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == DEPTH_C);
  assign valid   = (count != '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & valid;

  // Gate the head so outputs read as zero after reset, when memory is stale.
  assign head = valid ? mem[rd_ptr] : '0;
  assign {a_out, b_out, erase_a_out, erase_b_out, last_out} = head;

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= {a, b, erase_a, erase_b, last};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      if (do_push && !do_pop) begin
        count <= count + (AW+1)'(1);
      end else if (do_pop && !do_push) begin
        count <= count - (AW+1)'(1);
      end
    end
  end

endmodule

// File: rtl/wifi_rx_depuncture34.sv
// Rate-3/4 receive depuncturer: rebuilds mother-code pairs (A, B) from the
// received order A0 B0 A1 B2, inserting zero-valued erasures for B1 and A2,
// and queues them for the Viterbi decoder.
// Ports:
//   clk, reset                  clock and synchronous active-high reset
//   valid_in, data_in,
//   start_in, last_in, in_ready punctured soft-bit input with framing
//   valid_out, ready_out        output pair handshake
//   data_a_out, data_b_out,
//   erase_a_out, erase_b_out,
//   last_out                    output pair fields
//   err_out                     one-cycle framing error pulse
//
// phase | meaning
// PH_A0 | expecting A0 (first bit of a group), held until B0 arrives
// PH_B0 | expecting B0, completes pair (A0, B0)
// PH_A1 | expecting A1, completes pair (A1, erased B1)
// PH_B2 | expecting B2, completes pair (erased A2, B2)
module wifi_rx_depuncture34
  import wifi_rx_depuncture34_pkg::*;
#(
  parameter int SOFT_W     = SOFT_W_DEFAULT,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              valid_in,
  input  logic [SOFT_W-1:0] data_in,
  input  logic              start_in,
  input  logic              last_in,
  output logic              in_ready,
  output logic              valid_out,
  input  logic              ready_out,
  output logic [SOFT_W-1:0] data_a_out,
  output logic [SOFT_W-1:0] data_b_out,
  output logic              erase_a_out,
  output logic              erase_b_out,
  output logic              last_out,
  output logic              err_out
);

  phase_t            phase;
  phase_t            phase_nxt;
  phase_t            eff_phase;
  logic [SOFT_W-1:0] a0;
  logic [SOFT_W-1:0] a0_nxt;
  logic              err_nxt;
  logic              accept;
  logic              full;
  logic              push;
  logic [SOFT_W-1:0] push_a;
  logic [SOFT_W-1:0] push_b;
  logic              push_ea;
  logic              push_eb;
  logic              push_last;

  assign in_ready = ~full;
  assign accept   = valid_in & in_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      phase   <= PH_A0;
      a0      <= '0;
      err_out <= 1'b0;
    end else begin
      phase   <= phase_nxt;
      a0      <= a0_nxt;
      err_out <= err_nxt;
    end
  end

  always_comb begin
    eff_phase = phase;
    phase_nxt = phase;
    a0_nxt    = a0;
    err_nxt   = 1'b0;
    push      = 1'b0;
    push_a    = '0;
    push_b    = '0;
    push_ea   = 1'b0;
    push_eb   = 1'b0;
    push_last = 1'b0;
    // A start realigns to a fresh group regardless of where we were.
    if (start_in) eff_phase = PH_A0;
    if (accept) begin
      err_nxt   = (start_in && (phase != PH_A0)) || (last_in && (eff_phase != PH_B2));
      push_last = last_in;
      case (eff_phase)
        PH_A0: begin
          if (last_in) begin
            // Truncated group: B0 never arrives, so it is emitted as an erasure.
            push      = 1'b1;
            push_a    = data_in;
            push_eb   = 1'b1;
            phase_nxt = PH_A0;
          end else begin
            a0_nxt    = data_in;
            phase_nxt = PH_B0;
          end
        end
        PH_B0: begin
          push   = 1'b1;
          push_a = a0;
          push_b = data_in;
          if (last_in) phase_nxt = PH_A0;
          else         phase_nxt = PH_A1;
        end
        PH_A1: begin
          push    = 1'b1;
          push_a  = data_in;
          push_eb = ERASE_B1;
          if (last_in) phase_nxt = PH_A0;
          else         phase_nxt = PH_B2;
        end
        PH_B2: begin
          push      = 1'b1;
          push_b    = data_in;
          push_ea   = ERASE_A2;
          phase_nxt = PH_A0;
        end
        default: phase_nxt = PH_A0;
      endcase
    end
  end

  wifi_rx_depuncturer_fifo #(
    .SOFT_W (SOFT_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk         (clk),
    .reset       (reset),
    .push        (push),
    .a           (push_a),
    .b           (push_b),
    .erase_a     (push_ea),
    .erase_b     (push_eb),
    .last        (push_last),
    .pop         (ready_out),
    .full        (full),
    .valid       (valid_out),
    .a_out       (data_a_out),
    .b_out       (data_b_out),
    .erase_a_out (erase_a_out),
    .erase_b_out (erase_b_out),
    .last_out    (last_out)
  );

endmodule

// File: tb/tb_wifi_rx_depuncture34.sv
// Self-checking bench for wifi_rx_depuncture34. The reference model expands
// each received group onto the six mother-code positions using the keep
// mask and emits every pair whose positions are all known.
module tb_wifi_rx_depuncture34;

  localparam int SW = 3;
  localparam int FD = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          valid_in;
  logic [SW-1:0] data_in;
  logic          start_in;
  logic          last_in;
  logic          in_ready;
  logic          valid_out;
  logic          ready_out;
  logic [SW-1:0] data_a_out;
  logic [SW-1:0] data_b_out;
  logic          erase_a_out;
  logic          erase_b_out;
  logic          last_out;
  logic          err_out;

  wifi_rx_depuncture34 #(.SOFT_W(SW), .FIFO_DEPTH(FD)) dut (
    .clk         (clk),
    .reset       (reset),
    .valid_in    (valid_in),
    .data_in     (data_in),
    .start_in    (start_in),
    .last_in     (last_in),
    .in_ready    (in_ready),
    .valid_out   (valid_out),
    .ready_out   (ready_out),
    .data_a_out  (data_a_out),
    .data_b_out  (data_b_out),
    .erase_a_out (erase_a_out),
    .erase_b_out (erase_b_out),
    .last_out    (last_out),
    .err_out     (err_out)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int rdy_mode = 1;        // 0: hold low, 1: hold high, 2: random
  int err_seen = 0;
  int exp_err = 0;
  int pops = 0;
  logic [8:0] exp_q[$];    // {a, b, erase_a, erase_b, last}
  logic [8:0] got_q[$];

  // Reference model state: position in the received group and the
  // mother-code positions filled so far.
  int         grp_k = 0;
  int         emitted = 0;
  logic [2:0] mv[6];
  bit         filled[6];
  int         kept[4] = '{0, 1, 2, 5};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic void model_clear();
    grp_k = 0;
    emitted = 0;
    for (int i = 0; i < 6; i++) filled[i] = 1'b0;
  endfunction

  function automatic void model_bit(input logic [2:0] d, input bit s, input bit l);
    int m;
    int nm;
    int upto;
    bit e;
    e = 1'b0;
    if (s) begin
      if (grp_k != 0) e = 1'b1;
      model_clear();
    end
    m = kept[grp_k];
    mv[m] = d;
    filled[m] = 1'b1;
    if (l) begin
      upto = m / 2;
      if (grp_k != 3) e = 1'b1;
    end else begin
      nm = (grp_k < 3) ? kept[grp_k + 1] : 6;
      upto = nm / 2 - 1;
    end
    for (int p = emitted; p <= upto; p++) begin
      logic [2:0] a;
      logic [2:0] b;
      bit ea;
      bit eb;
      ea = !filled[2*p];
      eb = !filled[2*p+1];
      a  = ea ? 3'd0 : mv[2*p];
      b  = eb ? 3'd0 : mv[2*p+1];
      exp_q.push_back({a, b, ea, eb, (l && p == upto)});
    end
    if (upto + 1 > emitted) emitted = upto + 1;
    if (l || grp_k == 3) model_clear();
    else grp_k++;
    if (e) exp_err++;
  endfunction

  task automatic to_drive();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) to_drive();
  endtask

  // Called at posedge+1; returns at posedge+1 after the bit was accepted.
  task automatic send(input logic [2:0] d, input bit s, input bit l);
    int w;
    w = 0;
    valid_in = 1'b1;
    data_in  = d;
    start_in = s;
    last_in  = l;
    @(negedge clk);
    while (!in_ready && w < 300) begin
      @(negedge clk);
      w++;
    end
    if (in_ready) model_bit(d, s, l);
    else chk("send_timeout", {31'd0, in_ready}, 32'd1);
    to_drive();
    valid_in = 1'b0;
    start_in = 1'b0;
    last_in  = 1'b0;
    data_in  = 3'($urandom_range(0, 7));
  endtask

  task automatic drain();
    int w;
    w = 0;
    rdy_mode = 1;
    while (exp_q.size() != 0 && w < 500) begin
      to_drive();
      w++;
    end
    idle(3);
    chk("drain_empty", exp_q.size(), 0);
  endtask

  initial begin
    ready_out = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       ready_out = 1'b0;
        1:       ready_out = 1'b1;
        default: ready_out = ($urandom_range(0, 3) != 0);
      endcase
    end
  end

  // Scoreboard: the presented pair must always be the oldest expected one.
  initial begin
    forever begin
      logic [8:0] obs;
      @(negedge clk);
      if (!reset && valid_out) begin
        obs = {data_a_out, data_b_out, erase_a_out, erase_b_out, last_out};
        total++;
        assert (exp_q.size() != 0) else begin
          bad++;
          $error("FAIL pair_extra observed=%0h expected=none", obs);
        end
        if (exp_q.size() != 0) begin
          total++;
          assert (obs === exp_q[0]) else begin
            bad++;
            $error("FAIL pair observed=%0h expected=%0h", obs, exp_q[0]);
          end
        end
        if (ready_out) begin
          if (exp_q.size() != 0) void'(exp_q.pop_front());
          got_q.push_back(obs);
          pops++;
        end
      end
      if (!reset && err_out) err_seen++;
    end
  end

  initial begin
    int base_err;
    int base_pops;
    logic [2:0] d;
    int len;
    reset    = 1'b1;
    valid_in = 1'b0;
    data_in  = '0;
    start_in = 1'b0;
    last_in  = 1'b0;
    model_clear();
    idle(3);
    reset = 1'b0;

    // Reset state
    @(negedge clk);
    chk("rst_valid_out", {31'd0, valid_out}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_err_out", {31'd0, err_out}, 32'd0);
    chk("rst_data_a", {29'd0, data_a_out}, 32'd0);
    chk("rst_data_b", {29'd0, data_b_out}, 32'd0);
    chk("rst_flags", {29'd0, erase_a_out, erase_b_out, last_out}, 32'd0);
    to_drive();

    // Basic frame 1,2,3,-4
    rdy_mode = 1;
    idle(2);
    got_q.delete();
    base_err = err_seen;
    send(3'd1, 1'b1, 1'b0);
    send(3'd2, 1'b0, 1'b0);
    @(negedge clk);
    chk("latency1_valid", {31'd0, valid_out}, 32'd1);
    to_drive();
    send(3'd3, 1'b0, 1'b0);
    send(3'b100, 1'b0, 1'b1);
    drain();
    chk("basic_count", got_q.size(), 3);
    chk("basic_p0", {23'd0, got_q[0]}, {23'd0, 3'd1, 3'd2, 3'b000});
    chk("basic_p1", {23'd0, got_q[1]}, {23'd0, 3'd3, 3'd0, 3'b010});
    chk("basic_p2", {23'd0, got_q[2]}, {23'd0, 3'd0, 3'b100, 3'b101});
    chk("basic_err", err_seen - base_err, 0);

    // Backpressure: 48 bits with the decoder stalled at first
    rdy_mode = 0;
    idle(2);
    got_q.delete();
    base_pops = pops;
    for (int i = 0; i < 6; i++) send(3'(i + 1), (i == 0), 1'b0);
    @(negedge clk);
    chk("bp_in_ready_low", {31'd0, in_ready}, 32'd0);
    chk("bp_valid_held", {31'd0, valid_out}, 32'd1);
    to_drive();
    rdy_mode = 1;
    for (int i = 6; i < 48; i++) send(3'($urandom_range(0, 7)), 1'b0, (i == 47));
    drain();
    chk("bp_pop_count", pops - base_pops, 36);

    // Last on a phase-0 bit
    got_q.delete();
    base_err = err_seen;
    send(3'd2, 1'b1, 1'b1);
    @(negedge clk);
    chk("last_ph0_err_pulse", {31'd0, err_out}, 32'd1);
    to_drive();
    drain();
    chk("last_ph0_count", got_q.size(), 1);
    chk("last_ph0_pair", {23'd0, got_q[0]}, {23'd0, 3'd2, 3'd0, 3'b011});
    chk("last_ph0_err_once", err_seen - base_err, 1);

    // Start arriving at phase 2
    got_q.delete();
    base_err = err_seen;
    send(3'd5, 1'b1, 1'b0);
    send(3'd6, 1'b0, 1'b0);
    send(3'd7, 1'b1, 1'b0);
    @(negedge clk);
    chk("restart_err_pulse", {31'd0, err_out}, 32'd1);
    to_drive();
    send(3'd1, 1'b0, 1'b0);
    send(3'd2, 1'b0, 1'b0);
    send(3'd3, 1'b0, 1'b1);
    drain();
    chk("restart_count", got_q.size(), 4);
    chk("restart_p0", {23'd0, got_q[0]}, {23'd0, 3'd5, 3'd6, 3'b000});
    chk("restart_p1", {23'd0, got_q[1]}, {23'd0, 3'd7, 3'd1, 3'b000});
    chk("restart_p2", {23'd0, got_q[2]}, {23'd0, 3'd2, 3'd0, 3'b010});
    chk("restart_p3", {23'd0, got_q[3]}, {23'd0, 3'd0, 3'd3, 3'b101});
    chk("restart_err_once", err_seen - base_err, 1);

    // Reset with three pairs queued
    rdy_mode = 0;
    idle(2);
    for (int i = 0; i < 4; i++) send(3'(i + 4), (i == 0), 1'b0);
    @(negedge clk);
    chk("rst_mid_queued", {31'd0, valid_out}, 32'd1);
    to_drive();
    reset = 1'b1;
    to_drive();
    reset = 1'b0;
    exp_q.delete();
    model_clear();
    @(negedge clk);
    chk("rst_mid_valid_out", {31'd0, valid_out}, 32'd0);
    chk("rst_mid_in_ready", {31'd0, in_ready}, 32'd1);
    to_drive();
    rdy_mode = 1;
    got_q.delete();
    for (int i = 0; i < 4; i++) send(3'(i + 1), (i == 0), (i == 3));
    drain();
    chk("rst_mid_after_count", got_q.size(), 3);

    // Random traffic over 1000 frames
    rdy_mode = 2;
    for (int f = 0; f < 1000; f++) begin
      len = $urandom_range(1, 12);
      for (int i = 0; i < len; i++) begin
        if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 2));
        d = 3'($urandom_range(0, 7));
        send(d, (i == 0), (i == len - 1));
      end
    end
    drain();
    chk("err_total", err_seen, exp_err);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
